// File: rtl/ring_pkg.sv
// Shared ring slot encodings, header layout and station state type
// for the per-core ring station.
package ring_pkg;

  localparam logic [3:0] SLOT_TOKEN   = 4'd1;
  localparam logic [3:0] SLOT_NULL    = 4'd7;
  localparam logic [3:0] SLOT_MESSAGE = 4'd8;

  localparam int HDR_DEST_LSB  = 14;
  localparam int HDR_FIELD_W   = 4;
  localparam int LEN_W_DEFAULT = 6;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HELD = 1'b1
  } station_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  slot_type;
    logic [3:0]  source;
  } ring_slot_t;

  localparam ring_slot_t NULL_SLOT  = '{data: 32'd0, slot_type: SLOT_NULL,  source: 4'd0};
  localparam ring_slot_t TOKEN_SLOT = '{data: 32'd0, slot_type: SLOT_TOKEN, source: 4'd0};

  function automatic logic [3:0] hdr_dest(input logic [31:0] word);
    return word[HDR_DEST_LSB +: HDR_FIELD_W];
  endfunction

endpackage

// File: rtl/ring_rr_arb.sv
// Two-way round-robin arbiter for the ring token; on a tie the client
// that did not win most recently is granted.
module ring_rr_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] want,
  input  logic       enable,
  output logic [1:0] grant
);

  logic rr_last_r;

  // Grant selection; rr_last_r resets to client 1 so client 0 wins the first tie
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (want)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_last_r ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end else begin
      grant = 2'b00;
    end
  end

  // Remember the most recent winner
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_last_r <= 1'b1;
    end else if (grant != 2'b00) begin
      rr_last_r <= grant[1];
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

endmodule

// File: rtl/ring_station.sv
// Per-core ring node: registers the ring slot, strips messages addressed to
// this core, and owns/arbitrates the token between the Messenger and aux client.
module ring_station
  import ring_pkg::*;
#(
  parameter bit INJECT_TOKEN = 1'b0,
  parameter int LEN_W        = LEN_W_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  whichCore,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  input  logic        msgrWantsToken,
  output logic        msgrAcquireToken,
  input  logic        msgrDriveRing,
  input  logic [31:0] msgrRingOut,
  input  logic [3:0]  msgrSlotTypeOut,
  input  logic [3:0]  msgrSourceOut,
  input  logic        auxWantsToken,
  output logic        auxAcquireToken,
  input  logic        auxDriveRing,
  input  logic [31:0] auxRingOut,
  input  logic [3:0]  auxSlotTypeOut,
  input  logic [3:0]  auxSourceOut,
  output logic        tokenHeld,
  output logic        ringOverrun
);

  station_state_e state_r, state_s;
  logic             owner_r, owner_s;
  logic [LEN_W-1:0] in_len_r;
  logic             strip_r;
  logic             inject_r;
  logic             token_held_r;
  logic             overrun_r, overrun_s;
  ring_slot_t       out_r, out_s;
  ring_slot_t       in_slot_s, pass_slot_s, msgr_slot_s, aux_slot_s, owner_slot_s;
  logic             owner_drive_s;
  logic             is_header_s, dest_hit_s, strip_now_s, arb_en_s;
  logic [1:0]       grant_s;

  assign in_slot_s   = '{data: RingIn, slot_type: SlotTypeIn, source: SourceIn};
  assign msgr_slot_s = '{data: msgrRingOut, slot_type: msgrSlotTypeOut, source: msgrSourceOut};
  assign aux_slot_s  = '{data: auxRingOut, slot_type: auxSlotTypeOut, source: auxSourceOut};

  assign owner_slot_s  = owner_r ? aux_slot_s : msgr_slot_s;
  assign owner_drive_s = owner_r ? auxDriveRing : msgrDriveRing;

  // Header cycles decide stripping from the live dest field, payload cycles from the latched flag
  assign is_header_s = (in_len_r == {LEN_W{1'b0}}) && (SlotTypeIn == SLOT_MESSAGE);
  assign dest_hit_s  = (hdr_dest(RingIn) == whichCore);
  assign strip_now_s = is_header_s ? dest_hit_s : ((in_len_r != {LEN_W{1'b0}}) && strip_r);
  assign pass_slot_s = strip_now_s ? NULL_SLOT : in_slot_s;

  assign arb_en_s = (state_r == ST_PASS) && (SlotTypeIn == SLOT_TOKEN) && !inject_r;

  ring_rr_arb u_arb (
    .clock  (clock),
    .reset  (reset),
    .want   ({auxWantsToken, msgrWantsToken}),
    .enable (arb_en_s),
    .grant  (grant_s)
  );

  assign msgrAcquireToken = grant_s[0];
  assign auxAcquireToken  = grant_s[1];

  // Token FSM and output slot selection
  always_comb begin
    state_s   = state_r;
    owner_s   = owner_r;
    out_s     = pass_slot_s;
    overrun_s = overrun_r;
    if (inject_r) begin
      out_s = TOKEN_SLOT;
    end else begin
      case (state_r)
        ST_PASS: begin
          if (grant_s != 2'b00) begin
            state_s = ST_HELD;
            owner_s = grant_s[1];
            if (grant_s[1]) begin
              out_s = auxDriveRing ? aux_slot_s : NULL_SLOT;
            end else begin
              out_s = msgrDriveRing ? msgr_slot_s : NULL_SLOT;
            end
          end else if (SlotTypeIn == SLOT_TOKEN) begin
            out_s = in_slot_s;
          end else begin
            out_s = pass_slot_s;
          end
        end
        ST_HELD: begin
          if (owner_drive_s) begin
            out_s = owner_slot_s;
          end else begin
            out_s   = TOKEN_SLOT;
            state_s = ST_PASS;
          end
          // Anything real that we cannot strip is lost while we own the ring
          if (!strip_now_s && (SlotTypeIn != SLOT_NULL)) begin
            overrun_s = 1'b1;
          end else begin
            overrun_s = overrun_r;
          end
        end
        default: begin
          state_s = ST_PASS;
          out_s   = NULL_SLOT;
        end
      endcase
    end
  end

  // Message header / payload length tracker
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_len_r <= {LEN_W{1'b0}};
      strip_r  <= 1'b0;
    end else if (in_len_r != {LEN_W{1'b0}}) begin
      in_len_r <= in_len_r - {{(LEN_W-1){1'b0}}, 1'b1};
    end else if (SlotTypeIn == SLOT_MESSAGE) begin
      in_len_r <= RingIn[LEN_W-1:0];
      strip_r  <= dest_hit_s;
    end else begin
      in_len_r <= in_len_r;
    end
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_PASS;
      owner_r      <= 1'b0;
      inject_r     <= INJECT_TOKEN;
      token_held_r <= 1'b0;
      overrun_r    <= 1'b0;
      out_r        <= NULL_SLOT;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      inject_r     <= 1'b0;
      token_held_r <= (state_s == ST_HELD);
      overrun_r    <= overrun_s;
      out_r        <= out_s;
    end
  end

  assign RingOut     = out_r.data;
  assign SlotTypeOut = out_r.slot_type;
  assign SourceOut   = out_r.source;
  assign tokenHeld   = token_held_r;
  assign ringOverrun = overrun_r;

endmodule

// File: tb/tb_ring_station.sv
// Self-checking bench for ring_station: slot-level behavioural model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_ring_station;

  localparam logic [3:0] T_TOKEN = 4'd1;
  localparam logic [3:0] T_NULL  = 4'd7;
  localparam logic [3:0] T_MSG   = 4'd8;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  whichCore;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn, SourceIn;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut, SourceOut;
  logic        msgrWantsToken, msgrAcquireToken, msgrDriveRing;
  logic [31:0] msgrRingOut;
  logic [3:0]  msgrSlotTypeOut, msgrSourceOut;
  logic        auxWantsToken, auxAcquireToken, auxDriveRing;
  logic [31:0] auxRingOut;
  logic [3:0]  auxSlotTypeOut, auxSourceOut;
  logic        tokenHeld, ringOverrun;

  ring_station #(.INJECT_TOKEN(1'b1), .LEN_W(6)) dut (
    .clock(clock), .reset(reset), .whichCore(whichCore),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .msgrWantsToken(msgrWantsToken), .msgrAcquireToken(msgrAcquireToken),
    .msgrDriveRing(msgrDriveRing), .msgrRingOut(msgrRingOut),
    .msgrSlotTypeOut(msgrSlotTypeOut), .msgrSourceOut(msgrSourceOut),
    .auxWantsToken(auxWantsToken), .auxAcquireToken(auxAcquireToken),
    .auxDriveRing(auxDriveRing), .auxRingOut(auxRingOut),
    .auxSlotTypeOut(auxSlotTypeOut), .auxSourceOut(auxSourceOut),
    .tokenHeld(tokenHeld), .ringOverrun(ringOverrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: what the station has emitted and what it remembers about the ring
  logic [31:0] e_data;
  logic [3:0]  e_type, e_src;
  bit          e_held, e_over;
  int          holder, remaining, last_win;
  bit          strip_msg, inject_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit wm, input bit wa, input int last);
    if (wm && wa) return (last == 0) ? 1 : 0;
    if (wm) return 0;
    if (wa) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] hdr(input logic [3:0] dst, input logic [3:0] src, input logic [5:0] len);
    return {14'd0, dst, src, 4'd0, len};
  endfunction

  task automatic emit(input logic [31:0] d, input logic [3:0] t, input logic [3:0] s);
    e_data = d; e_type = t; e_src = s;
  endtask

  task automatic model_reset();
    emit(32'd0, T_NULL, 4'd0);
    e_held = 1'b0; e_over = 1'b0;
    holder = -1; remaining = 0; last_win = 1;
    strip_msg = 1'b0; inject_pend = 1'b1;
  endtask

  task automatic model_step();
    int w;
    bit is_hdr, strip;
    is_hdr = (remaining == 0) && (SlotTypeIn == T_MSG);
    strip  = is_hdr ? (RingIn[17:14] == whichCore) : ((remaining > 0) && strip_msg);
    if (inject_pend) begin
      emit(32'd0, T_TOKEN, 4'd0);
      inject_pend = 1'b0;
    end else if (holder < 0) begin
      w = (SlotTypeIn == T_TOKEN) ? pick(msgrWantsToken, auxWantsToken, last_win) : -1;
      if (w == 0) begin
        holder = 0; last_win = 0;
        if (msgrDriveRing) emit(msgrRingOut, msgrSlotTypeOut, msgrSourceOut);
        else emit(32'd0, T_NULL, 4'd0);
      end else if (w == 1) begin
        holder = 1; last_win = 1;
        if (auxDriveRing) emit(auxRingOut, auxSlotTypeOut, auxSourceOut);
        else emit(32'd0, T_NULL, 4'd0);
      end else if (strip && SlotTypeIn != T_TOKEN) begin
        emit(32'd0, T_NULL, 4'd0);
      end else begin
        emit(RingIn, SlotTypeIn, SourceIn);
      end
    end else begin
      if (holder == 0 && msgrDriveRing) emit(msgrRingOut, msgrSlotTypeOut, msgrSourceOut);
      else if (holder == 1 && auxDriveRing) emit(auxRingOut, auxSlotTypeOut, auxSourceOut);
      else begin
        emit(32'd0, T_TOKEN, 4'd0);
        holder = -1;
      end
      if (!strip && SlotTypeIn != T_NULL) e_over = 1'b1;
    end
    if (remaining > 0) remaining--;
    else if (is_hdr) begin
      remaining = int'(RingIn[5:0]);
      strip_msg = (RingIn[17:14] == whichCore);
    end
    e_held = (holder >= 0);
  endtask

  // Advance the model with the DUT
  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // Compare every cycle, mid-way between active edges
  always @(negedge clock) begin : compare
    int w;
    w = (reset && !inject_pend && holder < 0 && SlotTypeIn == T_TOKEN)
        ? pick(msgrWantsToken, auxWantsToken, last_win) : -1;
    chk("RingOut", RingOut, e_data);
    chk("SlotTypeOut", {28'd0, SlotTypeOut}, {28'd0, e_type});
    chk("SourceOut", {28'd0, SourceOut}, {28'd0, e_src});
    chk("tokenHeld", {31'd0, tokenHeld}, {31'd0, e_held});
    chk("ringOverrun", {31'd0, ringOverrun}, {31'd0, e_over});
    chk("msgrAcquireToken", {31'd0, msgrAcquireToken}, (w == 0) ? 32'd1 : 32'd0);
    chk("auxAcquireToken", {31'd0, auxAcquireToken}, (w == 1) ? 32'd1 : 32'd0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
    SlotTypeIn = t; RingIn = d; SourceIn = s;
  endtask

  initial begin
    reset = 1'b0; whichCore = 4'd3;
    put(T_NULL, 32'd0, 4'd0);
    msgrWantsToken = 1'b0; msgrDriveRing = 1'b0; msgrRingOut = 32'd0;
    msgrSlotTypeOut = T_MSG; msgrSourceOut = 4'd3;
    auxWantsToken = 1'b0; auxDriveRing = 1'b0; auxRingOut = 32'd0;
    auxSlotTypeOut = T_MSG; auxSourceOut = 4'd3;
    repeat (3) tick();
    chk("rst_type", {28'd0, SlotTypeOut}, 32'd7);
    chk("rst_held", {31'd0, tokenHeld}, 32'd0);

    // Injected token appears exactly once after reset
    reset = 1'b1;
    tick();
    chk("inject_token", {28'd0, SlotTypeOut}, 32'd1);
    tick();
    chk("after_inject", {28'd0, SlotTypeOut}, 32'd7);

    // Tie: Messenger first, aux on the next token
    msgrWantsToken = 1'b1; auxWantsToken = 1'b1;
    put(T_TOKEN, 32'd0, 4'd0);
    #1;
    chk("tie_msgr_grant", {31'd0, msgrAcquireToken}, 32'd1);
    chk("tie_aux_wait", {31'd0, auxAcquireToken}, 32'd0);
    tick();
    msgrWantsToken = 1'b0;
    chk("grant_no_drive", {28'd0, SlotTypeOut}, 32'd7);
    chk("held_after_grant", {31'd0, tokenHeld}, 32'd1);
    put(T_NULL, 32'd0, 4'd0);
    tick();
    chk("release_token", {28'd0, SlotTypeOut}, 32'd1);
    put(T_TOKEN, 32'd0, 4'd0);
    #1;
    chk("aux_turn", {31'd0, auxAcquireToken}, 32'd1);
    tick();
    auxWantsToken = 1'b0;
    put(T_NULL, 32'd0, 4'd0);
    tick();

    // Messenger sends header + 3 payload words, then releases
    msgrWantsToken = 1'b1; msgrDriveRing = 1'b1; msgrRingOut = hdr(4'd5, 4'd3, 6'd3);
    put(T_TOKEN, 32'd0, 4'd0);
    #1;
    chk("msgr_grant", {31'd0, msgrAcquireToken}, 32'd1);
    tick();
    msgrWantsToken = 1'b0;
    put(T_NULL, 32'd0, 4'd0);
    chk("hdr_out", RingOut, hdr(4'd5, 4'd3, 6'd3));
    for (int i = 1; i <= 3; i++) begin
      msgrRingOut = 32'hA0 + i;
      tick();
      chk("payload_out", RingOut, 32'hA0 + i);
      chk("payload_type", {28'd0, SlotTypeOut}, 32'd8);
    end
    msgrDriveRing = 1'b0;
    tick();
    chk("msg_release", {28'd0, SlotTypeOut}, 32'd1);

    // Stripping: dest=3 len=2 vanishes, dest=5 len=2 passes
    put(T_MSG, hdr(4'd3, 4'd5, 6'd2), 4'd5); tick();
    chk("strip_hdr", {28'd0, SlotTypeOut}, 32'd7);
    put(T_MSG, 32'h1111, 4'd5); tick();
    chk("strip_p1", RingOut, 32'd0);
    put(T_MSG, 32'h2222, 4'd5); tick();
    chk("strip_p2", {28'd0, SlotTypeOut}, 32'd7);
    put(T_MSG, hdr(4'd5, 4'd4, 6'd2), 4'd4); tick();
    chk("pass_hdr", RingOut, hdr(4'd5, 4'd4, 6'd2));
    put(T_MSG, 32'h3333, 4'd4); tick();
    chk("pass_p1", RingOut, 32'h3333);
    put(T_MSG, 32'h4444, 4'd4); tick();
    chk("pass_p2_src", {28'd0, SourceOut}, 32'd4);

    // Broadcasts: own returns stripped (len 0 strips one slot), foreign passed
    put(T_MSG, hdr(4'd3, 4'd3, 6'd0), 4'd3); tick();
    chk("own_bcast", {28'd0, SlotTypeOut}, 32'd7);
    put(4'd4, 32'h5555, 4'd2); tick();
    chk("after_len0", RingOut, 32'h5555);
    put(T_MSG, hdr(4'd5, 4'd5, 6'd0), 4'd5); tick();
    chk("other_bcast", RingOut, hdr(4'd5, 4'd5, 6'd0));

    // Overrun while held
    msgrWantsToken = 1'b1; msgrDriveRing = 1'b1; msgrRingOut = hdr(4'd6, 4'd3, 6'd2);
    put(T_TOKEN, 32'd0, 4'd0); tick();
    msgrWantsToken = 1'b0;
    put(T_MSG, hdr(4'd3, 4'd7, 6'd0), 4'd7); msgrRingOut = 32'hB1; tick();
    chk("held_strip_no_ovr", {31'd0, ringOverrun}, 32'd0);
    chk("held_out_b1", RingOut, 32'hB1);
    put(T_MSG, hdr(4'd5, 4'd7, 6'd0), 4'd7); msgrRingOut = 32'hB2; tick();
    chk("overrun_set", {31'd0, ringOverrun}, 32'd1);
    chk("held_out_b2", RingOut, 32'hB2);
    put(T_NULL, 32'd0, 4'd0); msgrDriveRing = 1'b0; tick();
    chk("ovr_release", {28'd0, SlotTypeOut}, 32'd1);

    // Ungranted client drive is ignored; overrun stays sticky
    auxDriveRing = 1'b1; auxRingOut = 32'hDEAD; tick();
    chk("ungranted_ignored", {28'd0, SlotTypeOut}, 32'd7);
    chk("overrun_sticky", {31'd0, ringOverrun}, 32'd1);
    auxDriveRing = 1'b0;
    tick();

    // Mid-operation reset clears everything and re-injects
    reset = 1'b0;
    #1;
    chk("midrst_overrun", {31'd0, ringOverrun}, 32'd0);
    chk("midrst_type", {28'd0, SlotTypeOut}, 32'd7);
    tick();
    reset = 1'b1;
    tick();
    chk("reinject_token", {28'd0, SlotTypeOut}, 32'd1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
